// File: rtl/memory_access_if.sv
// -----------------------------------------------------------------------------
// memory_access_if
//
// Data-memory request/acknowledge bus between the memory_access pipeline stage
// (master) and the data memory (slave).
//
// Signals:
//   req    master->slave  request valid, held until ack
//   we     master->slave  1 = write, 0 = read
//   addr   master->slave  word-aligned byte address
//   wdata  master->slave  lane-replicated store data
//   be     master->slave  byte enables, bit i enables byte lane i
//   ack    slave->master  transaction complete, rdata valid this cycle
//   rdata  slave->master  read data
// -----------------------------------------------------------------------------
interface memory_access_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        be;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, rdata
    );
endinterface

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
//
// Pipeline stage following execute. Non-memory instructions pass straight
// through in one cycle. Loads and stores run a request/acknowledge transaction
// on the data-memory bus, with load data aligned and extended before
// write-back. The upstream pipeline is stalled while a transaction is pending.
//
// Ports:
//   clk, reset               rising-edge clock, asynchronous active-low reset
//   pipeline_in_valid        input bundle valid
//   PC_in, mem_op, mem_size  instruction PC, memory op (00 none, 01 load,
//                            10 store, 11 none), access size (00 b, 01 h, 10 w)
//   load_unsigned            zero-extend (1) or sign-extend (0) loads
//   alu_result               effective address or non-memory result
//   store_data, rd_addr      store operand, destination register
//   excep_in                 upstream exception vector
//   flush, stall_in          squash this stage, downstream stall
//   stall_req                upstream must hold
//   dmem                     data-memory bus (master side)
//   pipeline_out_valid       output bundle valid
//   PC_out, rd_addr_out      PC and destination register of output instruction
//   wb_data, wb_en           write-back value and register-file write enable
//   excep_out                exception vector, bit 0 = misaligned access
// -----------------------------------------------------------------------------
module memory_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int EX_W   = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              pipeline_in_valid,
    input  logic [ADDR_W-1:0] PC_in,
    input  logic [1:0]        mem_op,
    input  logic [1:0]        mem_size,
    input  logic              load_unsigned,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [4:0]        rd_addr,
    input  logic [EX_W-1:0]   excep_in,
    input  logic              flush,
    input  logic              stall_in,
    output logic              stall_req,

    memory_access_if.master   dmem,

    output logic              pipeline_out_valid,
    output logic [ADDR_W-1:0] PC_out,
    output logic [4:0]        rd_addr_out,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_en,
    output logic [EX_W-1:0]   excep_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,  // request outstanding
        DONE     = 2'd2,  // result buffered, waiting for downstream
        DRAIN    = 2'd3   // flushed while a request is outstanding
    } state_t;

    // Everything the write-back stage sees for one instruction.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] pc;
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
        logic              wb_en;
        logic [EX_W-1:0]   excep;
    } bundle_t;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [3:0]        be;
    } request_t;

    // Instruction details kept while its transaction is in flight.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [4:0]        rd;
        logic [1:0]        size;
        logic              uns;
        logic [1:0]        offset;
        logic              is_load;
    } pending_t;

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;

    state_t   state_q, state_d;
    bundle_t  out_q, out_d;
    bundle_t  buf_q, buf_d;
    request_t req_q, req_d;
    pending_t pend_q, pend_d;

    // -------------------------------------------------------------------------
    // Load lane selection and extension
    // -------------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] align_load(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        offset,
        input logic [1:0]        size,
        input logic              uns
    );
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = word[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: align_load = uns ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_HALF: align_load = uns ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: align_load = word;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Decode of the incoming instruction
    // -------------------------------------------------------------------------
    logic            is_mem;
    logic            misaligned;
    logic            issue;
    logic [EX_W-1:0] excep_all;
    logic [1:0]      offset;
    bundle_t         pass_bundle;
    bundle_t         mem_bundle;
    request_t        new_req;
    pending_t        new_pend;

    always_comb begin
        offset     = alu_result[1:0];
        is_mem     = (mem_op == OP_LOAD) || (mem_op == OP_STORE);
        // Sizes 10 and 11 are both treated as word accesses.
        misaligned = is_mem &&
                     (((mem_size == SZ_HALF) && offset[0]) ||
                      (mem_size[1] && (offset != 2'b00)));
        excep_all  = excep_in | {{(EX_W-1){1'b0}}, misaligned};
        // Any exception, including our own misalignment, suppresses the bus.
        issue      = is_mem && (excep_all == '0);

        pass_bundle.valid = 1'b1;
        pass_bundle.pc    = PC_in;
        pass_bundle.rd    = rd_addr;
        pass_bundle.data  = alu_result;
        pass_bundle.wb_en = (rd_addr != 5'd0) && (excep_all == '0);
        pass_bundle.excep = excep_all;

        new_req.req  = 1'b1;
        new_req.we   = (mem_op == OP_STORE);
        new_req.addr = {alu_result[ADDR_W-1:2], 2'b00};
        case (mem_size)
            SZ_BYTE: begin
                new_req.be    = 4'b0001 << offset;
                new_req.wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                new_req.be    = 4'b0011 << {offset[1], 1'b0};
                new_req.wdata = {2{store_data[15:0]}};
            end
            default: begin
                new_req.be    = 4'b1111;
                new_req.wdata = store_data;
            end
        endcase

        new_pend.pc      = PC_in;
        new_pend.rd      = rd_addr;
        new_pend.size    = mem_size;
        new_pend.uns     = load_unsigned;
        new_pend.offset  = offset;
        new_pend.is_load = (mem_op == OP_LOAD);

        // Completed-transaction result; only meaningful while ack is high.
        mem_bundle.valid = 1'b1;
        mem_bundle.pc    = pend_q.pc;
        mem_bundle.rd    = pend_q.rd;
        mem_bundle.data  = pend_q.is_load
                         ? align_load(dmem.rdata, pend_q.offset, pend_q.size, pend_q.uns)
                         : '0;
        mem_bundle.wb_en = pend_q.is_load && (pend_q.rd != 5'd0);
        mem_bundle.excep = '0;
    end

    // -------------------------------------------------------------------------
    // Next-state and next-register logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every target gets its hold value first so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        out_d   = out_q;
        buf_d   = buf_q;
        req_d   = req_q;
        pend_d  = pend_q;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    out_d.valid = 1'b0;
                end else if (!stall_in) begin
                    if (pipeline_in_valid && issue) begin
                        req_d       = new_req;
                        pend_d      = new_pend;
                        out_d.valid = 1'b0;
                        state_d     = WAIT_ACK;
                    end else if (pipeline_in_valid) begin
                        out_d = pass_bundle;
                    end else begin
                        out_d.valid = 1'b0;
                    end
                end
            end

            WAIT_ACK: begin
                if (flush) begin
                    // The bus transaction cannot be withdrawn; only its result
                    // is dropped. If ack arrives now there is nothing to drain.
                    out_d.valid = 1'b0;
                    if (dmem.ack) begin
                        req_d.req = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        state_d   = DRAIN;
                    end
                end else if (dmem.ack) begin
                    req_d.req = 1'b0;
                    if (stall_in) begin
                        buf_d   = mem_bundle;
                        state_d = DONE;
                    end else begin
                        out_d   = mem_bundle;
                        state_d = IDLE;
                        // stall_req drops in the ack cycle, so upstream
                        // advances now and its instruction must be taken.
                        // A pass-through result cannot share the output
                        // register this edge and is parked in DONE instead.
                        if (pipeline_in_valid && issue) begin
                            req_d   = new_req;
                            pend_d  = new_pend;
                            state_d = WAIT_ACK;
                        end else if (pipeline_in_valid) begin
                            buf_d   = pass_bundle;
                            state_d = DONE;
                        end
                    end
                end else if (!stall_in) begin
                    out_d.valid = 1'b0;
                end
            end

            DONE: begin
                if (flush) begin
                    out_d.valid = 1'b0;
                    state_d     = IDLE;
                end else if (!stall_in) begin
                    out_d   = buf_q;
                    state_d = IDLE;
                end
            end

            DRAIN: begin
                if (dmem.ack) begin
                    req_d.req   = 1'b0;
                    out_d.valid = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments let every register sample the
        // pre-edge values, independent of statement order.
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the buffers are reset along with the visible outputs; an async
        // reset mid-transaction must drop dmem.req at once, and no stale
        // bundle can reappear after reset.
        if (!reset) begin
            out_q  <= '0;
            buf_q  <= '0;
            req_q  <= '0;
            pend_q <= '0;
        end else begin
            out_q  <= out_d;
            buf_q  <= buf_d;
            req_q  <= req_d;
            pend_q <= pend_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign stall_req = stall_in
                     | ((state_q == WAIT_ACK) & ~dmem.ack)
                     | (state_q == DONE)
                     | (state_q == DRAIN);

    assign dmem.req   = req_q.req;
    assign dmem.we    = req_q.we;
    assign dmem.addr  = req_q.addr;
    assign dmem.wdata = req_q.wdata;
    assign dmem.be    = req_q.be;

    assign pipeline_out_valid = out_q.valid;
    assign PC_out             = out_q.pc;
    assign rd_addr_out        = out_q.rd;
    assign wb_data            = out_q.data;
    assign wb_en              = out_q.wb_en;
    assign excep_out          = out_q.excep;

endmodule

// File: doc/memory_access.md
# memory_access

Pipeline stage directly downstream of `execute`. It takes the executed instruction's result and, for loads and stores, runs a request/acknowledge transaction on the data-memory port. It aligns and extends load data, produces write-back data for the register-file stage, and stalls the upstream pipeline while a memory transaction is outstanding.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width. Fixed at 32; byte enables are 4 bits.
- `EX_W`, 4: exception vector width. Bit 0 is the misaligned-access flag added by this block.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `pipeline_in_valid`  in  1  the input bundle is valid.
- `PC_in`  in  ADDR_W  PC of the incoming instruction.
- `mem_op`  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none).
- `mem_size`  in  2  00 byte, 01 half, 10 word.
- `load_unsigned`  in  1  zero-extend loads (1) or sign-extend them (0).
- `alu_result`  in  DATA_W  effective address, or the result for non-memory operations.
- `store_data`  in  DATA_W  store source operand.
- `rd_addr`  in  5  destination register.
- `excep_in`  in  EX_W  upstream exceptions.
- `flush`  in  1  squash the instruction in this stage.
- `stall_in`  in  1  downstream stall.
- `stall_req`  out  1  upstream must hold.
- `dmem_req`  out  1  request valid.
- `dmem_we`  out  1  write (1) or read (0).
- `dmem_addr`  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- `dmem_wdata`  out  DATA_W  lane-replicated store data.
- `dmem_be`  out  4  byte enables.
- `dmem_ack`  in  1  transaction complete; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata`  in  DATA_W  read data.
- `pipeline_out_valid`  out  1  the output bundle is valid.
- `PC_out`  out  ADDR_W  PC of the output instruction.
- `rd_addr_out`  out  5  destination register of the output instruction.
- `wb_data`  out  DATA_W  write-back value.
- `wb_en`  out  1  write the register file.
- `excep_out`  out  EX_W  exception vector of the output instruction.

## Operation
- FSM states:
  - IDLE.
  - WAIT_ACK: request outstanding.
  - DONE: ack received while `stall_in` was high; result buffered.
  - DRAIN: flushed while a request is outstanding.
- All registered outputs are 0 at reset, and the FSM resets to IDLE.
- **Accept condition:** in IDLE, `pipeline_in_valid` high, `stall_in` low, `flush` low.
- **Non-memory operation:**
  - Output registers load on the next edge.
  - `wb_data`=`alu_result`.
  - `wb_en`=(`rd_addr`!=0 and no exception).
- **Misalignment:** half access with addr[0]=1, or word access with addr[1:0]!=0.
  - `excep_out`=`excep_in`|1, `wb_en`=0.
  - No request is issued; the instruction passes through in one cycle.
- **Upstream exception:** if `excep_in`!=0, no request is issued and `wb_en`=0.
- **Load/store:** the request registers load, state goes to WAIT_ACK, and `dmem_req`=1 from the next cycle.
  - All `dmem_*` outputs stay stable until ack.
  - Byte store: `be`=0001<<addr[1:0], `wdata`={4{byte}}.
  - Half store: `be`=0011<<{addr[1],0}, `wdata`={2{half}}.
  - Word store: `be`=1111.
  - Loads: `be` is computed the same way and `we`=0.
- **Ack handling in WAIT_ACK** (`dmem_ack`=1):
  - Next edge: `dmem_req`=0 and the output bundle is loaded.
  - Load result: the selected lane (by addr[1:0]), extended per `load_unsigned`. `wb_en`=(`rd_addr`!=0).
  - Store: `wb_en`=0.
  - If `stall_in`=1 in the ack cycle, `rdata` is captured into a buffer and the state goes to DONE. DONE emits on the first cycle with `stall_in`=0, then returns to IDLE.
- **`stall_req`** = `stall_in` | (WAIT_ACK & ~`dmem_ack`) | DONE | DRAIN.
- **`stall_in` high in IDLE:** all outputs hold their values.
- **Flush:**
  - In IDLE or DONE: `pipeline_out_valid`<=0 and state goes to IDLE.
  - In WAIT_ACK: the bus transaction cannot be cancelled. `dmem_req` stays high until ack, the state goes to DRAIN, and the result is discarded. A store still writes memory.
  - DRAIN returns to IDLE on ack with `pipeline_out_valid`=0.
- **`pipeline_out_valid`** is a one-cycle pulse per instruction unless held by `stall_in`.

## Timing
- Non-memory instruction: 1-cycle latency (input at edge N, output valid after edge N+1).
- Load/store with ack in the first request cycle: `dmem_req` is high for cycle N+1 and the output is valid after edge N+2. Total latency is 2 + (ack wait cycles).
- Back-to-back accept: a new instruction may be accepted on the same edge that the previous memory result is emitted.
- An async reset mid-transaction drops `dmem_req` immediately. Memory must tolerate this abort.

## Test plan
- ALU passthrough: `alu_result`=0x1234, `rd_addr`=5, `mem_op`=0 → one cycle later `pipeline_out_valid`=1, `wb_data`=0x1234, `wb_en`=1, `dmem_req`=0.
- Signed byte load: addr 0x103, `rdata`=0x80FFFFFF, ack after 2 wait cycles → `stall_req` high for 2 cycles, `wb_data`=0xFFFFFF80. With `load_unsigned`=1 → 0x00000080.
- Half store: addr 0x102, `store_data`=0xAAAABEEF → `dmem_addr`=0x100, `be`=1100, `wdata`=0xBEEFBEEF, `we`=1, `wb_en`=0.
- Misaligned word load at 0x101 → `dmem_req` never rises, `excep_out` bit0=1, `wb_en`=0, 1-cycle latency.
- Flush in WAIT_ACK with ack 3 cycles later → `dmem_req` held until ack, `pipeline_out_valid` stays 0, state returns to IDLE.
- Ack coinciding with `stall_in`=1 for 2 cycles → result emitted on the first cycle after `stall_in` falls, with the correct data. Drive reset low mid-request → all outputs 0 immediately.
